// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync: brings the opposite domain's Gray pointer into the clk
// domain and turns it into a binary pointer plus FIFO level and flags.
// WRSIDE=0 builds the read-side view (empty), WRSIDE=1 the write-side
// view (full). Optional Gray step checker: FIFO_PTR_SYNC_GRAYCHK_EN.
module fifo_ptr_sync #(
   parameter int ADDRWIDTH = 6,
   parameter int WRSIDE    = 0,
   parameter int ALMOSTTHR = 4
) (
   input  logic                 clk,
   input  logic                 hardReset_n,
   input  logic                 flush,
   input  logic [ADDRWIDTH:0]   localPtr,
   input  logic [ADDRWIDTH:0]   remoteGray,
   output logic [ADDRWIDTH:0]   remoteBin,
   output logic [ADDRWIDTH:0]   fifoLevel,
   output logic                 fifoEmpty,
   output logic                 fifoFull,
   output logic                 fifoAlmost,
   output logic                 ptrError
);

   localparam int PW = ADDRWIDTH + 1;
   // Level of a completely full FIFO: only the wrap bit set.
   localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};
   localparam logic [ADDRWIDTH:0] THR   = PW'(ALMOSTTHR);
   localparam logic [ADDRWIDTH:0] HIGH_MARK = DEPTH - THR;

   logic [ADDRWIDTH:0] sync1_reg;
   logic [ADDRWIDTH:0] sync2_reg;
   logic [ADDRWIDTH:0] remote_bin_reg;
   logic               ptr_error_reg;
   logic [ADDRWIDTH:0] sync2_bin;
   logic [ADDRWIDTH:0] level;
   logic               level_over;
   logic               gray_err;

   // Gray to binary: each binary bit is the parity of all Gray bits at or
   // above it, which is the MSB-down XOR chain written without feedback.
   genvar gi;
   generate
      for (gi = 0; gi <= ADDRWIDTH; gi++) begin : g_gray2bin
         assign sync2_bin[gi] = ^sync2_reg[ADDRWIDTH:gi];
      end
   endgenerate

   // Modular subtraction keeps the level correct across pointer wrap.
   generate
      if (WRSIDE != 0) begin : g_wr_level
         assign level      = localPtr - remote_bin_reg;
         assign fifoAlmost = (level >= HIGH_MARK);
      end else begin : g_rd_level
         assign level      = remote_bin_reg - localPtr;
         assign fifoAlmost = (level <= THR);
      end
   endgenerate

   assign fifoLevel  = level;
   assign fifoEmpty  = (level == '0);
   assign fifoFull   = (level == DEPTH);
   assign level_over = (level > DEPTH);
   assign remoteBin  = remote_bin_reg;
   assign ptrError   = ptr_error_reg;

`ifdef FIFO_PTR_SYNC_GRAYCHK_EN
   logic [ADDRWIDTH:0] prev_sync2_reg;
   logic [ADDRWIDTH:0] gray_step;

   // A legal Gray sequence changes at most one bit per sample; more than
   // one set bit in the difference means a corrupted or skipped pointer.
   assign gray_step = sync2_reg ^ prev_sync2_reg;
   assign gray_err  = ((gray_step & (gray_step - PW'(1))) != '0);

   // Remember the previous synchronized Gray value for the step check.
   always_ff @(posedge clk or negedge hardReset_n) begin
      if (!hardReset_n) begin
         prev_sync2_reg <= '0;
      end else if (flush) begin
         prev_sync2_reg <= '0;
      end else begin
         prev_sync2_reg <= sync2_reg;
      end
   end
`else
   assign gray_err = 1'b0;
`endif

   // Two-flop synchronizer followed by the registered binary conversion.
   always_ff @(posedge clk or negedge hardReset_n) begin
      if (!hardReset_n) begin
         sync1_reg      <= '0;
         sync2_reg      <= '0;
         remote_bin_reg <= '0;
      end else if (flush) begin
         sync1_reg      <= '0;
         sync2_reg      <= '0;
         remote_bin_reg <= '0;
      end else begin
         sync1_reg      <= remoteGray;
         sync2_reg      <= sync1_reg;
         remote_bin_reg <= sync2_bin;
      end
   end

   // Sticky integrity error: impossible level or illegal Gray step.
   always_ff @(posedge clk or negedge hardReset_n) begin
      if (!hardReset_n) begin
         ptr_error_reg <= 1'b0;
      end else if (flush) begin
         ptr_error_reg <= 1'b0;
      end else begin
         ptr_error_reg <= ptr_error_reg | level_over | gray_err;
      end
   end

endmodule

// File: tb/tb_fifo_ptr_sync.sv
// Bench for fifo_ptr_sync: one read-side and one write-side instance run
// side by side. Stimulus pushes the expected post-edge outputs, computed
// from a sample-history model, into a queue; a monitor pops and compares.
module tb_fifo_ptr_sync;

   logic            clk;
   logic            hardReset_n;
   logic            flush;
   logic [1:0][6:0] lp_i;
   logic [1:0][6:0] gray_i;
   logic [1:0][6:0] rb_o;
   logic [1:0][6:0] lvl_o;
   logic [1:0]      emp_o, ful_o, alm_o, err_o;

   typedef struct packed {
      logic [1:0][6:0] rb;
      logic [1:0][6:0] lvl;
      logic [1:0]      emp;
      logic [1:0]      ful;
      logic [1:0]      alm;
      logic [1:0]      err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;

   // stimulus globals
   int g_in[2];
   int lp_in[2];
   bit fl_in;
   bit rst_in;
   int cnt[2];

   // reference model: the last three Gray samples taken, newest first
   int m_hist[2][3];
   int m_rb[2];
   bit m_err[2];

   fifo_ptr_sync #(.ADDRWIDTH(6), .WRSIDE(0), .ALMOSTTHR(4)) u_rd (
      .clk(clk), .hardReset_n(hardReset_n), .flush(flush),
      .localPtr(lp_i[0]), .remoteGray(gray_i[0]), .remoteBin(rb_o[0]),
      .fifoLevel(lvl_o[0]), .fifoEmpty(emp_o[0]), .fifoFull(ful_o[0]),
      .fifoAlmost(alm_o[0]), .ptrError(err_o[0])
   );

   fifo_ptr_sync #(.ADDRWIDTH(6), .WRSIDE(1), .ALMOSTTHR(4)) u_wr (
      .clk(clk), .hardReset_n(hardReset_n), .flush(flush),
      .localPtr(lp_i[1]), .remoteGray(gray_i[1]), .remoteBin(rb_o[1]),
      .fifoLevel(lvl_o[1]), .fifoEmpty(emp_o[1]), .fifoFull(ful_o[1]),
      .fifoAlmost(alm_o[1]), .ptrError(err_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int b2g(int b);
      return (b ^ (b >> 1)) & 127;
   endfunction

   function automatic int g2b(int g);
      int b = 0;
      int t = g;
      while (t != 0) begin
         b = b ^ t;
         t = t >> 1;
      end
      return b & 127;
   endfunction

   // side 0 = read side, side 1 = write side
   function automatic int lvl_of(int s, int rb, int lp);
      return (s != 0) ? ((lp - rb) & 127) : ((rb - lp) & 127);
   endfunction

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 3; k++) m_hist[s][k] = 0;
         m_rb[s]  = 0;
         m_err[s] = 1'b0;
      end
   endfunction

   function automatic exp_t make_exp();
      exp_t e;
      for (int s = 0; s < 2; s++) begin
         int l;
         l = lvl_of(s, m_rb[s], lp_in[s]);
         e.rb[s]  = 7'(m_rb[s]);
         e.lvl[s] = 7'(l);
         e.emp[s] = (l == 0);
         e.ful[s] = (l == 64);
         e.alm[s] = (s != 0) ? (l >= 60) : (l <= 4);
         e.err[s] = m_err[s];
      end
      return e;
   endfunction

   // Apply the stimulus globals at a falling edge and predict the state
   // after the following rising edge.
   task automatic tick();
      @(negedge clk);
      hardReset_n = rst_in;
      flush       = fl_in;
      for (int s = 0; s < 2; s++) begin
         gray_i[s] = 7'(g_in[s]);
         lp_i[s]   = 7'(lp_in[s]);
      end
      if (fl_in || !rst_in) begin
         model_clear();
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (lvl_of(s, m_rb[s], lp_in[s]) > 64) m_err[s] = 1'b1;
`ifdef FIFO_PTR_SYNC_GRAYCHK_EN
            if ($countones(m_hist[s][1] ^ m_hist[s][2]) > 1) m_err[s] = 1'b1;
`endif
            m_hist[s][2] = m_hist[s][1];
            m_hist[s][1] = m_hist[s][0];
            m_hist[s][0] = g_in[s];
            m_rb[s]      = g2b(m_hist[s][2]);
         end
      end
      exp_q.push_back(make_exp());
   endtask

   task automatic set_all(int g0, int lp0, int g1, int lp1, bit fl);
      g_in[0] = g0; lp_in[0] = lp0; g_in[1] = g1; lp_in[1] = lp1; fl_in = fl;
   endtask

   task automatic do_flush();
      set_all(0, 0, 0, 0, 1'b1);
      cnt[0] = 0; cnt[1] = 0;
      tick();
      fl_in = 1'b0;
   endtask

   // Monitor: one comparison set per rising edge that has a prediction.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         txn++;
         for (int s = 0; s < 2; s++) begin
            string sd;
            sd = (s != 0) ? "wr" : "rd";
            chk({sd, ".remoteBin"},  int'(rb_o[s]),  int'(e.rb[s]));
            chk({sd, ".fifoLevel"},  int'(lvl_o[s]), int'(e.lvl[s]));
            chk({sd, ".fifoEmpty"},  int'(emp_o[s]), int'(e.emp[s]));
            chk({sd, ".fifoFull"},   int'(ful_o[s]), int'(e.ful[s]));
            chk({sd, ".fifoAlmost"}, int'(alm_o[s]), int'(e.alm[s]));
            chk({sd, ".ptrError"},   int'(err_o[s]), int'(e.err[s]));
         end
         $display("txn %0d rd: rb=%0d lvl=%0d err=%0d | wr: rb=%0d lvl=%0d full=%0d err=%0d",
                  txn, rb_o[0], lvl_o[0], err_o[0], rb_o[1], lvl_o[1], ful_o[1], err_o[1]);
      end
   end

   initial begin
      hardReset_n = 1'b0;
      flush       = 1'b0;
      lp_i        = '0;
      gray_i      = '0;
      rst_in      = 1'b0;
      cnt[0] = 0; cnt[1] = 0;
      set_all(0, 0, 0, 0, 1'b0);
      model_clear();

      // Outputs while held in reset, before any clock edge.
      #3;
      chk("reset.rd.remoteBin", int'(rb_o[0]), 0);
      chk("reset.rd.fifoLevel", int'(lvl_o[0]), 0);
      chk("reset.rd.fifoEmpty", int'(emp_o[0]), 1);
      chk("reset.rd.fifoFull", int'(ful_o[0]), 0);
      chk("reset.rd.fifoAlmost", int'(alm_o[0]), 1);
      chk("reset.wr.fifoAlmost", int'(alm_o[1]), 0);
      chk("reset.wr.fifoEmpty", int'(emp_o[1]), 1);
      chk("reset.ptrError", int'(err_o), 0);

      repeat (2) tick();
      rst_in = 1'b1;
      tick();

      // Latency: read side, remote 0 -> 1, remoteBin follows on the 3rd edge.
      set_all(b2g(1), 0, 0, 0, 1'b0);
      repeat (4) tick();

      // Ramp both remotes one step at a time; read side towards wrap,
      // write side settles at 100.
      for (int i = 2; i <= 127; i++) begin
         g_in[0]  = b2g(i);
         lp_in[0] = i - 3;
         if (i <= 100) begin
            g_in[1]  = b2g(i);
            lp_in[1] = i;
         end
         tick();
      end
      repeat (3) tick();
      // Write side: local wrapped to 36 against remote 100 -> full.
      lp_in[1] = 36;
      lp_in[0] = 127;
      repeat (3) tick();
      // Read side wrap: remote 127 -> 0 -> 1 against local 127.
      g_in[0] = b2g(0);
      repeat (4) tick();
      g_in[0] = b2g(1);
      repeat (4) tick();

      // Impossible level on the write side sets the sticky error.
      do_flush();
      for (int i = 1; i <= 10; i++) begin
         g_in[1]  = b2g(i);
         lp_in[1] = i;
         tick();
      end
      repeat (3) tick();
      lp_in[1] = 80;
      repeat (3) tick();
      do_flush();
      repeat (2) tick();

      // Gray jump 0 -> 3 on the read side.
      g_in[0] = 3;
      repeat (5) tick();
      do_flush();

      // Asynchronous reset in the middle of traffic.
      for (int i = 1; i <= 6; i++) begin
         g_in[0] = b2g(i); g_in[1] = b2g(i); lp_in[1] = i;
         tick();
      end
      @(negedge clk);
      hardReset_n = 1'b0;
      rst_in      = 1'b0;
      model_clear();
      #1;
      chk("async_rst.rd.remoteBin", int'(rb_o[0]), 0);
      chk("async_rst.wr.remoteBin", int'(rb_o[1]), 0);
      chk("async_rst.wr.fifoLevel", int'(lvl_o[1]), 6);
      set_all(0, 0, 0, 0, 1'b0);
      repeat (2) tick();
      rst_in = 1'b1;
      cnt[0] = 0; cnt[1] = 0;
      tick();

      // Randomized traffic with single-step Gray pointers and occasional flush.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            do_flush();
         end else begin
            for (int s = 0; s < 2; s++) begin
               int r;
               cnt[s]  = (cnt[s] + int'($urandom_range(0, 1))) & 127;
               g_in[s] = b2g(cnt[s]);
               r       = int'($urandom_range(0, 66));
               lp_in[s] = (s != 0) ? ((cnt[s] + r) & 127) : ((cnt[s] - r) & 127);
            end
            tick();
         end
      end

      // Drain the scoreboard within a bounded number of edges.
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
